// File: rtl/dm_pkg.sv
// dm_pkg: shared size encodings, FSM states and ctrl decode for dm_arbiter
package dm_pkg;
  localparam logic [2:0] DM_BYTE  = 3'b000;
  localparam logic [2:0] DM_HALF  = 3'b001;
  localparam logic [2:0] DM_WORD  = 3'b010;
  localparam logic [2:0] DM_BYTEU = 3'b100;
  localparam logic [2:0] DM_HALFU = 3'b101;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef struct packed {
    logic       legal;
    logic [2:0] size;
  } ctrl_info_t;
  function automatic ctrl_info_t decode_ctrl(input logic [2:0] ctrl);
    ctrl_info_t i;
    i.legal = ctrl inside {DM_BYTE, DM_HALF, DM_WORD, DM_BYTEU, DM_HALFU};
    i.size  = ctrl[1:0] == 2'b00 ? 3'd1 : ctrl[1:0] == 2'b01 ? 3'd2 : 3'd4;
    return i;
  endfunction
endpackage

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: two requester/response ports plus the data memory pins
interface dm_arbiter_if #(parameter int ADDR_W = 32);
  logic              req0_valid, req0_ready, req0_wr;
  logic [ADDR_W-1:0] req0_addr;
  logic [31:0]       req0_wdata;
  logic [2:0]        req0_ctrl;
  logic              rsp0_valid, rsp0_err;
  logic [31:0]       rsp0_rdata;
  logic              req1_valid, req1_ready, req1_wr;
  logic [ADDR_W-1:0] req1_addr;
  logic [31:0]       req1_wdata;
  logic [2:0]        req1_ctrl;
  logic              rsp1_valid, rsp1_err;
  logic [31:0]       rsp1_rdata;
  logic [ADDR_W-1:0] address;
  logic [31:0]       datawr, datard;
  logic              dmwr;
  logic [2:0]        dmctrl;
  modport slave (
    input  req0_valid, req0_addr, req0_wdata, req0_wr, req0_ctrl,
    input  req1_valid, req1_addr, req1_wdata, req1_wr, req1_ctrl, datard,
    output req0_ready, rsp0_valid, rsp0_err, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_err, rsp1_rdata,
    output address, datawr, dmwr, dmctrl
  );
  modport master (
    output req0_valid, req0_addr, req0_wdata, req0_wr, req0_ctrl,
    output req1_valid, req1_addr, req1_wdata, req1_wr, req1_ctrl, datard,
    input  req0_ready, rsp0_valid, rsp0_err, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_err, rsp1_rdata,
    input  address, datawr, dmwr, dmctrl
  );
endinterface

// File: rtl/dm_rr_arb2.sv
// dm_rr_arb2: two-way round-robin picker; the port not granted last wins ties
module dm_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic advance,
  output logic gnt0,
  output logic gnt1
);
  logic last_grant;
  always_comb begin
    gnt0 = valid0 & (~valid1 | last_grant);
    gnt1 = valid1 & (~valid0 | ~last_grant);
  end
  always_ff @(posedge clk) begin
    if (rst) last_grant <= 1'b1;
    else if (advance) last_grant <= gnt1;
  end
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin sequencer of two requesters onto the byte-addressed data memory
module dm_arbiter #(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 32
) (
  input logic         clk,
  input logic         rst,
  dm_arbiter_if.slave bus
);
  import dm_pkg::*;
  state_t            state, state_n;
  logic              gnt0, gnt1, accept, err, port, r_wr, r_err, s_wr;
  logic [ADDR_W-1:0] s_addr;
  logic [ADDR_W:0]   last_byte;
  logic [31:0]       s_wdata, rdata0, rdata1;
  logic [2:0]        s_ctrl;
  ctrl_info_t        info;
  dm_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid0  (bus.req0_valid && state == IDLE),
    .valid1  (bus.req1_valid && state == IDLE),
    .advance (gnt0 | gnt1),
    .gnt0    (gnt0),
    .gnt1    (gnt1)
  );
  always_comb begin
    accept  = gnt0 | gnt1;
    s_addr  = gnt1 ? bus.req1_addr  : bus.req0_addr;
    s_wdata = gnt1 ? bus.req1_wdata : bus.req0_wdata;
    s_wr    = gnt1 ? bus.req1_wr    : bus.req0_wr;
    s_ctrl  = gnt1 ? bus.req1_ctrl  : bus.req0_ctrl;
    info    = decode_ctrl(s_ctrl);
    // one extra bit so an address near the top of the space overflows into err
    last_byte = {1'b0, s_addr} + (ADDR_W+1)'(info.size) - (ADDR_W+1)'(1);
    err     = ~info.legal | (last_byte > (ADDR_W+1)'(DEPTH - 1));
    state_n = state == IDLE ? (accept ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
    bus.req0_ready = gnt0;
    bus.req1_ready = gnt1;
    bus.dmwr       = state == ACCESS && r_wr && !r_err;
    bus.rsp0_valid = state == RESP && !port;
    bus.rsp1_valid = state == RESP && port;
    bus.rsp0_err   = state == RESP && !port && r_err;
    bus.rsp1_err   = state == RESP && port && r_err;
    bus.rsp0_rdata = rdata0;
    bus.rsp1_rdata = rdata1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bus.address <= '0;
      bus.datawr  <= '0;
      bus.dmctrl  <= '0;
      r_wr        <= 1'b0;
      r_err       <= 1'b0;
      port        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        bus.address <= s_addr;
        bus.datawr  <= s_wdata;
        bus.dmctrl  <= s_ctrl;
        r_wr        <= s_wr;
        r_err       <= err;
        port        <= gnt1;
      end
      if (state == ACCESS && port) rdata1 <= (r_wr || r_err) ? 32'd0 : bus.datard;
      if (state == ACCESS && !port) rdata0 <= (r_wr || r_err) ? 32'd0 : bus.datard;
    end
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed checks of dm_arbiter against a little-endian byte memory model
module tb_dm_arbiter;
  localparam int DEPTH = 4096;
  logic clk, rst;
  int errors = 0, checks = 0;
  dm_arbiter_if bus ();
  dm_arbiter #(.DEPTH(DEPTH), .ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  logic [7:0]  mem [DEPTH];
  logic [11:0] ma;
  logic [7:0]  b0, b1, b2, b3;
  always_comb begin
    ma = bus.address[11:0];
    b0 = mem[ma];
    b1 = mem[ma + 12'd1];
    b2 = mem[ma + 12'd2];
    b3 = mem[ma + 12'd3];
    case (bus.dmctrl)
      3'b000:  bus.datard = {{24{b0[7]}}, b0};
      3'b001:  bus.datard = {{16{b1[7]}}, b1, b0};
      3'b010:  bus.datard = {b3, b2, b1, b0};
      3'b100:  bus.datard = {24'd0, b0};
      3'b101:  bus.datard = {16'd0, b1, b0};
      default: bus.datard = 32'd0;
    endcase
  end
  always @(posedge clk) begin
    if (bus.dmwr) begin
      mem[ma] <= bus.datawr[7:0];
      if (bus.dmctrl[1:0] != 2'b00) mem[ma + 12'd1] <= bus.datawr[15:8];
      if (bus.dmctrl[1:0] == 2'b10) begin
        mem[ma + 12'd2] <= bus.datawr[23:16];
        mem[ma + 12'd3] <= bus.datawr[31:24];
      end
    end
  end
  typedef struct {
    bit acc, early, rv, rvo, rerr;
    int wc;
    logic [31:0] maddr, mdata, rdata;
  } res_t;
  task automatic set_port(input bit p, input bit v, input logic [31:0] a, d, input bit w, input logic [2:0] c);
    if (p) begin
      bus.req1_valid = v; bus.req1_addr = a; bus.req1_wdata = d; bus.req1_wr = w; bus.req1_ctrl = c;
    end else begin
      bus.req0_valid = v; bus.req0_addr = a; bus.req0_wdata = d; bus.req0_wr = w; bus.req0_ctrl = c;
    end
  endtask
  // issues one request and records what the memory pins and response ports show in each phase
  task automatic txn(input bit p, input logic [31:0] a, d, input bit w, input logic [2:0] c, output res_t r);
    r = '{acc: 0, early: 0, rv: 0, rvo: 0, rerr: 0, wc: 0, maddr: 0, mdata: 0, rdata: 0};
    @(negedge clk);
    set_port(p, 1'b1, a, d, w, c);
    for (int n = 0; n < 10 && !r.acc; n++) begin
      #1 r.acc = p ? bus.req1_ready : bus.req0_ready;
      @(negedge clk);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    if (r.acc) begin
      r.wc = int'(bus.dmwr);
      r.maddr = bus.address;
      r.mdata = bus.datawr;
      r.early = bus.rsp0_valid | bus.rsp1_valid;
      @(negedge clk);
      r.wc += int'(bus.dmwr);
      r.rv = p ? bus.rsp1_valid : bus.rsp0_valid;
      r.rvo = p ? bus.rsp0_valid : bus.rsp1_valid;
      r.rerr = p ? bus.rsp1_err : bus.rsp0_err;
      r.rdata = p ? bus.rsp1_rdata : bus.rsp0_rdata;
      @(negedge clk);
      r.wc += int'(bus.dmwr);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_err, bus.rsp1_err, bus.dmwr} !== 7'd0) begin
      errors++; $display("FAIL reset_flags: got %b want 0000000", {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_err, bus.rsp1_err, bus.dmwr});
    end
    checks++;
    if (bus.address !== 32'd0) begin errors++; $display("FAIL reset_address: got %h want 0", bus.address); end
    checks++;
    if (bus.datawr !== 32'd0) begin errors++; $display("FAIL reset_datawr: got %h want 0", bus.datawr); end
    checks++;
    if (bus.dmctrl !== 3'd0) begin errors++; $display("FAIL reset_dmctrl: got %b want 0", bus.dmctrl); end
    checks++;
    if ({bus.rsp0_rdata, bus.rsp1_rdata} !== 64'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", {bus.rsp0_rdata, bus.rsp1_rdata}); end
    rst = 1'b0;
  endtask
  task automatic test_store();
    res_t r;
    txn(1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 3'b010, r);
    checks++;
    if (r.acc !== 1'b1) begin errors++; $display("FAIL store_accept: got %b want 1", r.acc); end
    checks++;
    if (r.wc !== 1) begin errors++; $display("FAIL store_dmwr_cycles: got %0d want 1", r.wc); end
    checks++;
    if (r.maddr !== 32'h10) begin errors++; $display("FAIL store_address: got %h want 00000010", r.maddr); end
    checks++;
    if (r.mdata !== 32'hDEADBEEF) begin errors++; $display("FAIL store_datawr: got %h want deadbeef", r.mdata); end
    checks++;
    if ({r.early, r.rv, r.rvo, r.rerr} !== 4'b0100) begin errors++; $display("FAIL store_rsp: got early/rv/other/err=%b want 0100", {r.early, r.rv, r.rvo, r.rerr}); end
  endtask
  task automatic test_load();
    logic [31:0] la [3] = '{32'h13, 32'h13, 32'h12};
    logic [2:0]  lc [3] = '{3'b000, 3'b100, 3'b101};
    logic [31:0] le [3] = '{32'hFFFFFFDE, 32'h000000DE, 32'h0000DEAD};
    res_t r;
    for (int i = 0; i < 3; i++) begin
      txn(1'b0, la[i], 32'h0, 1'b0, lc[i], r);
      checks++;
      if ({r.acc, r.rv, r.rerr, r.wc[1:0]} !== 5'b11000) begin errors++; $display("FAIL load%0d_flags: got acc/rv/err/wc=%b want 11000", i, {r.acc, r.rv, r.rerr, r.wc[1:0]}); end
      checks++;
      if (r.rdata !== le[i]) begin errors++; $display("FAIL load%0d_rdata: got %h want %h", i, r.rdata, le[i]); end
    end
    checks++;
    if (bus.rsp0_valid !== 1'b0 || bus.rsp0_rdata !== 32'h0000DEAD) begin errors++; $display("FAIL load_hold: got valid=%b rdata=%h want 0/0000dead", bus.rsp0_valid, bus.rsp0_rdata); end
  endtask
  task automatic test_errors();
    logic [31:0] ea [6] = '{32'h10, 32'h10, 32'd4094, 32'd4092, 32'd4092, 32'hFFFFFFFE};
    logic [31:0] ed [6] = '{32'h0, 32'h0, 32'hAAAAAAAA, 32'h12345678, 32'h0, 32'h0};
    bit          ew [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0]  ec [6] = '{3'b011, 3'b010, 3'b010, 3'b010, 3'b010, 3'b001};
    bit          xe [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int          xw [6] = '{0, 0, 0, 1, 0, 0};
    logic [31:0] xr [6] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h12345678, 32'h0};
    res_t r;
    for (int i = 0; i < 6; i++) begin
      txn(1'b0, ea[i], ed[i], ew[i], ec[i], r);
      checks++;
      if (r.acc !== 1'b1 || r.rv !== 1'b1 || r.rerr !== xe[i]) begin errors++; $display("FAIL err%0d_rsp: got acc/rv/err=%b%b%b want 11%b", i, r.acc, r.rv, r.rerr, xe[i]); end
      checks++;
      if (r.wc !== xw[i]) begin errors++; $display("FAIL err%0d_dmwr_cycles: got %0d want %0d", i, r.wc, xw[i]); end
      checks++;
      if (r.rdata !== xr[i]) begin errors++; $display("FAIL err%0d_rdata: got %h want %h", i, r.rdata, xr[i]); end
    end
  endtask
  task automatic test_contention();
    logic [3:0] exp;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    set_port(1'b0, 1'b1, 32'h10, 32'h0, 1'b0, 3'b010);
    set_port(1'b1, 1'b1, 32'd4092, 32'h0, 1'b0, 3'b010);
    for (int c = 0; c < 12; c++) begin
      #1 exp = {c % 6 == 0, c % 6 == 3, c % 6 == 2, c % 6 == 5};
      checks++;
      if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid} !== exp) begin
        errors++; $display("FAIL contention_c%0d: got rdy0/rdy1/rsp0/rsp1=%b want %b", c, {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid}, exp);
      end
      if (c == 2) begin
        checks++;
        if (bus.rsp0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL contention_rdata0: got %h want deadbeef", bus.rsp0_rdata); end
      end
      if (c == 5) begin
        checks++;
        if (bus.rsp1_rdata !== 32'h12345678) begin errors++; $display("FAIL contention_rdata1: got %h want 12345678", bus.rsp1_rdata); end
      end
      @(negedge clk);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    set_port(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 1'b1, 3'b010);
    #1 checks++;
    if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL mid_accept: got %b want 1", bus.req0_ready); end
    @(negedge clk);
    checks++;
    if (bus.dmwr !== 1'b1) begin errors++; $display("FAIL mid_access_dmwr: got %b want 1", bus.dmwr); end
    rst = 1'b1;
    bus.req0_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.dmwr, bus.rsp0_valid, bus.rsp1_valid} !== 3'b000) begin errors++; $display("FAIL mid_abort_c%0d: got dmwr/rsp0/rsp1=%b want 000", c, {bus.dmwr, bus.rsp0_valid, bus.rsp1_valid}); end
    end
    checks++;
    if (bus.address !== 32'd0) begin errors++; $display("FAIL mid_address: got %h want 0", bus.address); end
    rst = 1'b0;
    set_port(1'b0, 1'b1, 32'h10, 32'h0, 1'b0, 3'b010);
    set_port(1'b1, 1'b1, 32'h10, 32'h0, 1'b0, 3'b010);
    #1 checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL mid_first_grant: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_back_to_back();
    logic [31:0] la [3] = '{32'h100, 32'h102, 32'h104};
    logic [2:0]  lc [3] = '{3'b010, 3'b001, 3'b000};
    logic [31:0] le [3] = '{32'h44332211, 32'h00004433, 32'hFFFFFF80};
    res_t r;
    txn(1'b1, 32'h100, 32'h44332211, 1'b1, 3'b010, r);
    checks++;
    if (r.acc !== 1'b1 || r.wc !== 1) begin errors++; $display("FAIL b2b_preload0: got acc=%b wc=%0d want 1/1", r.acc, r.wc); end
    txn(1'b1, 32'h104, 32'h00000080, 1'b1, 3'b000, r);
    checks++;
    if (r.acc !== 1'b1 || r.wc !== 1) begin errors++; $display("FAIL b2b_preload1: got acc=%b wc=%0d want 1/1", r.acc, r.wc); end
    @(negedge clk);
    set_port(1'b1, 1'b1, la[0], 32'h0, 1'b0, lc[0]);
    for (int c = 0; c < 9; c++) begin
      #1 checks++;
      if ({bus.req1_ready, bus.req0_ready} !== {c % 3 == 0, 1'b0}) begin errors++; $display("FAIL b2b_ready_c%0d: got %b want %b", c, {bus.req1_ready, bus.req0_ready}, {c % 3 == 0, 1'b0}); end
      if (c % 3 == 2) begin
        checks++;
        if (bus.rsp1_valid !== 1'b1 || bus.rsp1_err !== 1'b0 || bus.rsp1_rdata !== le[c/3]) begin
          errors++; $display("FAIL b2b_rsp%0d: got valid=%b err=%b rdata=%h want 1/0/%h", c/3, bus.rsp1_valid, bus.rsp1_err, bus.rsp1_rdata, le[c/3]);
        end
      end
      @(negedge clk);
      if (c % 3 == 0 && c / 3 < 2) set_port(1'b1, 1'b1, la[c/3+1], 32'h0, 1'b0, lc[c/3+1]);
      else if (c == 6) bus.req1_valid = 1'b0;
    end
  endtask
  initial begin
    rst = 1'b1;
    set_port(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
    set_port(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
    test_reset();
    test_store();
    test_load();
    test_errors();
    test_contention();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
